// File: rtl/word_fetch_assembler_pkg.sv
// Shared constants for the byte-to-word fetch assembler: FSM encoding and word geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package word_fetch_assembler_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_W     = 8;

    // Legacy-compatible state encoding, 3 bits wide.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // Byte lane of the assembly register that receives fetched byte number idx.
    function automatic logic [1:0] byte_lane(input logic [1:0] idx, input logic big_endian);
        return big_endian ? (2'd3 - idx) : idx;
    endfunction

endpackage

// File: rtl/word_fetch_assembler.sv
// Fetches four consecutive bytes from a byte memory and presents them as one 32-bit word with a load strobe.
// Latency: zero-wait memory gives mem_rd in cycles T+1/3/5/7 and load in T+9 after start is sampled at T.
// Backpressure: none; start is ignored while busy, a byte missing for TIMEOUT cycles aborts with err.
module word_fetch_assembler
    import word_fetch_assembler_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [BYTE_W-1:0]     mem_data,
    input  logic                  mem_valid,
    output logic [31:0]           dout,
    output logic                  load,
    output logic                  busy,
    output logic                  err
);

    logic [2:0]                   state,  state_nxt;
    logic [1:0]                   idx,    idx_nxt;
    logic [7:0]                   tcnt,   tcnt_nxt;
    logic [ADDR_WIDTH-1:0]        base_q, base_nxt;
    logic [WORD_BYTES*BYTE_W-1:0] asm_q,  asm_nxt;
    logic [1:0]                   lane;

    assign lane = byte_lane(idx, BIG_ENDIAN);

    // Next-state, byte steering and timeout counting; data beats the timeout on the same edge.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tcnt_nxt  = tcnt;
        base_nxt  = base_q;
        asm_nxt   = asm_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    base_nxt  = base_addr;
                    idx_nxt   = 2'd0;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                tcnt_nxt  = 8'd0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    for (int i = 0; i < WORD_BYTES; i++) begin
                        if (2'(i) == lane) begin
                            asm_nxt[i*BYTE_W +: BYTE_W] = mem_data;
                        end
                    end
                    if (idx == 2'd3) begin
                        state_nxt = ST_DONE;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = ST_REQ;
                    end
                end else begin
                    tcnt_nxt = tcnt + 8'd1;
                    if (tcnt_nxt == 8'(TIMEOUT)) begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State update; every output is registered from the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            idx      <= 2'd0;
            tcnt     <= 8'd0;
            base_q   <= '0;
            asm_q    <= '0;
            dout     <= '0;
            load     <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            tcnt   <= tcnt_nxt;
            base_q <= base_nxt;
            asm_q  <= asm_nxt;
            mem_rd <= (state_nxt == ST_REQ);
            load   <= (state_nxt == ST_DONE);
            err    <= (state_nxt == ST_ERR);
            busy   <= (state_nxt != ST_IDLE);
            if (state_nxt == ST_REQ) begin
                mem_addr <= base_nxt + ADDR_WIDTH'(idx_nxt);
            end
            if (state_nxt == ST_DONE) begin
                dout <= asm_nxt;
            end
        end
    end

endmodule
